// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-library types and defaults
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand and result bundle
interface serial_subtractor_if
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor from two half subtractors
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    logic d1;
    logic b1;
    logic b2;

    // First stage subtracts y from x, second stage subtracts the borrow-in.
    half_subtractor u_hs_xy (
        .x  (x),
        .y  (y),
        .d  (d1),
        .bo (b1)
    );

    half_subtractor u_hs_bi (
        .x  (d1),
        .y  (bi),
        .d  (d),
        .bo (b2)
    );

    assign bo = b1 | b2;
endmodule

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - one-bit half subtractor (x - y)
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, one bit per clock
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    sub_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work;
    logic             borrow;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             busy_r;
    logic             done_r;
    logic             cell_d;
    logic             cell_bo;

    // The single shared arithmetic cell always looks at the LSBs of the operand shifters.
    full_subtractor u_fs (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (borrow),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Control FSM and datapath; results only land in diff/bout once all bits are done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            work   <= '0;
            borrow <= 1'b0;
            diff_r <= '0;
            bout_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        borrow <= bus.bin;
                        cnt    <= '0;
                        work   <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    work   <= {cell_d, work[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= cell_bo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff_r <= {cell_d, work[WIDTH-1:1]};
                        bout_r <= cell_bo;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   done_count = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("A=%0d B=%0d BIN=%0d | DIFF=%0d BOUT=%0d",
                         e.a, e.b, e.bin, bus.diff, bus.bout);
                check("diff", int'(bus.diff), int'(e.diff));
                check("bout", int'(bus.bout), int'(e.bout));
            end
        end
    end

    // Hand-derived reference: unsigned a - b - bin, borrow when a < b + bin.
    function automatic exp_t model(input int a, input int b, input int bin);
        exp_t e;
        e.a    = W'(a);
        e.b    = W'(b);
        e.bin  = bin[0];
        e.diff = W'((a - b - bin) & ((1 << W) - 1));
        e.bout = (a < (b + bin));
        return e;
    endfunction

    // Drives one start pulse (caller is just after a negedge); returns after the accept edge.
    task automatic issue(input int a, input int b, input int bin, input bit expect_result);
        bus.a     = W'(a);
        bus.b     = W'(b);
        bus.bin   = bin[0];
        bus.start = 1'b1;
        if (expect_result) exp_q.push_back(model(a, b, bin));
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Counts negedges after the accept edge until done, bounded.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.busy) bcnt++;
            if (bus.done) break;
        end
        if (!bus.done) check("done_timeout", 0, 1);
    endtask

    int lat;
    int bcnt;
    int d0;

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_diff", int'(bus.diff), 0);
        check("rst_bout", int'(bus.bout), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic latency and busy window: 9 - 3 - 0 = 6.
        issue(9, 3, 0, 1'b1);
        wait_done(lat, bcnt);
        check("latency", lat, 5);
        check("busy_cycles", bcnt, 4);
        check("busy_in_done", int'(bus.busy), 0);
        @(negedge clk);
        check("done_one_cycle", int'(bus.done), 0);
        check("diff_hold", int'(bus.diff), 6);

        // Borrow cases: 3-9-1 -> 9 b1, 0-0-1 -> 15 b1.
        issue(3, 9, 1, 1'b1);
        wait_done(lat, bcnt);
        @(negedge clk);
        issue(0, 0, 1, 1'b1);
        wait_done(lat, bcnt);
        @(negedge clk);

        // Exhaustive sweep; each op after the first is accepted in the prior DONE cycle.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    issue(a, b, bi, 1'b1);
                    wait_done(lat, bcnt);
                    check("sweep_latency", lat, 5);
                end
            end
        end
        @(negedge clk);

        // start during RUN must be ignored: 12 - 5 = 7, one done only.
        d0 = done_count;
        issue(12, 5, 0, 1'b1);
        @(negedge clk);
        bus.a     = W'(1);
        bus.b     = W'(2);
        bus.bin   = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (12) @(negedge clk);
        check("ignored_start_dones", done_count - d0, 1);
        check("ignored_start_diff", int'(bus.diff), 7);

        // Reset on the 2nd RUN cycle discards the operation.
        d0 = done_count;
        issue(10, 4, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_diff", int'(bus.diff), 0);
        check("abort_bout", int'(bus.bout), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", done_count - d0, 0);

        // Back-to-back: second start held in the DONE cycle; 15 - 1 = 14.
        issue(9, 3, 0, 1'b1);
        wait_done(lat, bcnt);
        check("b2b_first_done", int'(bus.done), 1);
        check("b2b_first_diff", int'(bus.diff), 6);
        issue(15, 1, 0, 1'b1);
        wait_done(lat, bcnt);
        check("b2b_latency", lat, 5);
        check("b2b_diff", int'(bus.diff), 14);
        check("b2b_bout", int'(bus.bout), 0);
        repeat (3) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor, the inverse-direction companion to the team's 4-bit ripple full adder. It computes a − b − bin one bit per clock through a single full-subtractor cell. It uses a start/busy/done handshake, so the datapath can share one cheap arithmetic cell across many operands. It sits beside the adder in the combinational/arithmetic library as the sequential, area-minimal subtraction path.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse: diff/bout valid and freshly updated
- diff  output  WIDTH  registered result, (a − b − bin) mod 2^WIDTH
- bout  output  1  registered borrow-out, 1 iff a < b + bin (unsigned)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1:
  - latch a, b into right-shift registers; load the borrow register with bin; clear the bit counter; go to RUN.
- RUN, each cycle:
  - apply the full-subtractor cell to a_sh[0], b_sh[0] and the borrow register.
  - shift the diff bit into the MSB of the work register.
  - shift a_sh and b_sh right; update the borrow register; increment the counter.
- After WIDTH RUN cycles:
  - copy the work register to diff and the final borrow to bout; go to DONE.
- DONE: done=1 for exactly this cycle.
  - With start=1: accept new operands exactly as in IDLE and go to RUN.
  - Otherwise go to IDLE.
- diff/bout hold their value until the next completion. They never show partial results.
- start while in RUN is ignored. It is not queued, and operand inputs are don't-care.
- Counter width: $clog2(WIDTH+1). It wraps nowhere; it is cleared on every accept.
- Full-subtractor equations:
  - d = x ^ y ^ bi
  - bo = (~x & y) | (~(x ^ y) & bi)

## Timing
- Reset values: busy=0, done=0, diff=0, bout=0, state=IDLE, all internal registers 0.
- rst has priority over everything, including mid-RUN and a coincident start. The operation in flight is discarded and no done is issued.
- Accept edge = the clk edge at which start=1 is sampled in IDLE or DONE.
- busy=1 from the cycle after the accept edge through the last RUN cycle, i.e. WIDTH cycles.
- done=1 and the new diff/bout appear in the cycle WIDTH+1 after the accept edge. The update occurs at the WIDTH-th edge after accept.
- busy=0 in the DONE cycle.
- Throughput: a back-to-back start in the DONE cycle gives one result per WIDTH+1 cycles.

## Structure
- Shared package arith_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t
  - localparam DEFAULT_WIDTH = 4
- One sub-module, full_subtractor:
  - ports x, y, bi, d, bo.
  - built from two half subtractors plus an OR, mirroring the adder's half-adder construction.
- Top: FSM, counter, a/b shift registers, work register, borrow register, output registers.

## Test plan
- a=9, b=3, bin=0, start pulse → done exactly 5 cycles after the accept edge; diff=6, bout=0; busy high for 4 cycles.
- a=3, b=9, bin=1 → diff=9, bout=1. a=0, b=0, bin=1 → diff=15, bout=1.
- Exhaustive WIDTH=4 sweep over all a, b, bin (512 cases) → diff and bout match the reference model every time; print A, B, BIN | DIFF, BOUT per case.
- start re-asserted during RUN with different operands → ignored; the original result is reported; one done only.
- rst asserted on the 2nd RUN cycle → next cycle busy=0, done=0, diff=0, bout=0; no done pulse follows.
- start held high in the DONE cycle with a=15, b=1, bin=0 → first result valid in the DONE cycle; second result diff=14, bout=0 exactly 5 cycles later.
